morning_alarm: RTL



---
 rtl/morning_alarm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/morning_alarm.sv
// Alarm controller for the morning clock.
// Resynchronises the running time count, compares it against a programmable alarm time and
// drives a buzzer square wave plus status flags. Supports snooze, manual stop and auto-timeout.
//
// Ports:
//   clk                  system clock
//   x_clr                synchronous active-low reset
//   sec_in/min_in/hour_in  running time, asynchronous to clk
//   alarm_en             level, alarm enabled
//   alarm_set            rising edge loads alarm_hour_in/alarm_min_in (if valid)
//   snooze_btn/stop_btn  debounced levels, rising edge is the event
//   alarm_hour/alarm_min stored alarm time
//   ringing              high while ringing
//   snooze_active        high while snoozing
//   buzzer               square wave while ringing, otherwise 0
module morning_alarm #(
  parameter int unsigned RING_SECONDS     = 60,
  parameter int unsigned SNOOZE_MINUTES   = 5,
  parameter int unsigned BUZZ_HALF_PERIOD = 25000,
  parameter int unsigned ALARM_RST_HOUR   = 6,
  parameter int unsigned ALARM_RST_MIN    = 30
) (
  input  logic       clk,
  input  logic       x_clr,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic       alarm_en,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour_in,
  input  logic [5:0] alarm_min_in,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       snooze_active,
  output logic       buzzer
);

  localparam int unsigned DivW = (BUZZ_HALF_PERIOD > 1) ? $clog2(BUZZ_HALF_PERIOD) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

  state_e state_q, state_d;

  // Two-flop synchronisers plus a delayed copy of seconds for tick detection.
  logic [5:0] sec_m, sec_s, sec_dly;
  logic [5:0] min_m, min_s;
  logic [4:0] hour_m, hour_s;
  logic       set_dly, snz_dly, stop_dly;

  logic [4:0] alarm_hour_q;
  logic [5:0] alarm_min_q;
  logic [4:0] snz_hour_q;
  logic [5:0] snz_min_q;
  logic [5:0] ring_cnt_q;
  logic [DivW-1:0] div_q;
  logic       buzzer_q, ringing_q, snooze_q;
  logic       ringing_d, snooze_d;

  logic       sec_tick, set_edge, snz_edge, stop_edge, load_valid, match;
  logic [4:0] tgt_hour;
  logic [5:0] tgt_min;
  logic [6:0] snz_sum;
  logic [4:0] snz_hour_d;
  logic [5:0] snz_min_d;

  always_ff @(posedge clk) begin
    if (!x_clr) begin
      sec_m    <= '0;
      sec_s    <= '0;
      sec_dly  <= '0;
      min_m    <= '0;
      min_s    <= '0;
      hour_m   <= '0;
      hour_s   <= '0;
      set_dly  <= 1'b0;
      snz_dly  <= 1'b0;
      stop_dly <= 1'b0;
    end else begin
      sec_m    <= sec_in;
      sec_s    <= sec_m;
      sec_dly  <= sec_s;
      min_m    <= min_in;
      min_s    <= min_m;
      hour_m   <= hour_in;
      hour_s   <= hour_m;
      set_dly  <= alarm_set;
      snz_dly  <= snooze_btn;
      stop_dly <= stop_btn;
    end
  end

  assign sec_tick   = (sec_s != sec_dly);
  assign set_edge   = alarm_set & ~set_dly;
  assign snz_edge   = snooze_btn & ~snz_dly;
  assign stop_edge  = stop_btn & ~stop_dly;
  assign load_valid = set_edge && (alarm_hour_in <= 5'd23) && (alarm_min_in <= 6'd59);

  // Compare target depends on whether we wait for the alarm or for the snooze expiry.
  assign tgt_hour = (state_q == StSnooze) ? snz_hour_q : alarm_hour_q;
  assign tgt_min  = (state_q == StSnooze) ? snz_min_q  : alarm_min_q;
  assign match    = sec_tick && (sec_s == 6'd0) && (hour_s == tgt_hour) && (min_s == tgt_min);

  assign snz_sum = {1'b0, min_s} + 7'(SNOOZE_MINUTES);
  always_comb begin
    snz_hour_d = hour_s;
    snz_min_d  = snz_sum[5:0];
    if (snz_sum >= 7'd60) begin
      snz_min_d  = 6'(snz_sum - 7'd60);
      snz_hour_d = (hour_s == 5'd23) ? 5'd0 : hour_s + 5'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!x_clr) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!alarm_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StArmed;
        StArmed: begin
          if (!load_valid && match) state_d = StRinging;
        end
        StRinging: begin
          if (load_valid || stop_edge) state_d = StArmed;
          else if (snz_edge)           state_d = StSnooze;
          else if (sec_tick && (ring_cnt_q == 6'(RING_SECONDS - 1))) state_d = StArmed;
        end
        StSnooze: begin
          if (load_valid || stop_edge) state_d = StArmed;
          else if (match)              state_d = StRinging;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode, registered below so the flags line up with state_q.
  always_comb begin
    ringing_d = (state_d == StRinging);
    snooze_d  = (state_d == StSnooze);
  end

  always_ff @(posedge clk) begin
    if (!x_clr) begin
      alarm_hour_q <= 5'(ALARM_RST_HOUR);
      alarm_min_q  <= 6'(ALARM_RST_MIN);
      snz_hour_q   <= '0;
      snz_min_q    <= '0;
      ring_cnt_q   <= '0;
      div_q        <= '0;
      buzzer_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snooze_q     <= 1'b0;
    end else begin
      ringing_q <= ringing_d;
      snooze_q  <= snooze_d;
      if (load_valid) begin
        alarm_hour_q <= alarm_hour_in;
        alarm_min_q  <= alarm_min_in;
      end
      if (state_q == StRinging && state_d == StSnooze) begin
        snz_hour_q <= snz_hour_d;
        snz_min_q  <= snz_min_d;
      end
      if (state_d == StRinging && state_q != StRinging) begin
        ring_cnt_q <= '0;
      end else if (state_q == StRinging && sec_tick) begin
        ring_cnt_q <= ring_cnt_q + 6'd1;
      end
      // Divider runs only while staying in RINGING; silenced on the exit edge.
      if (state_d != StRinging || state_q != StRinging) begin
        div_q    <= '0;
        buzzer_q <= 1'b0;
      end else if (div_q == DivW'(BUZZ_HALF_PERIOD - 1)) begin
        div_q    <= '0;
        buzzer_q <= ~buzzer_q;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  assign alarm_hour    = alarm_hour_q;
  assign alarm_min     = alarm_min_q;
  assign ringing       = ringing_q;
  assign snooze_active = snooze_q;
  assign buzzer        = buzzer_q;

endmodule
